// File: rtl/spawn_queue_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master among NREQ single-beat requesters.
// Optional address window/alignment check: define SPAWN_QUEUE_ARBITER_ADDR_CHECK_EN.
module spawn_queue_arbiter #(
  parameter int          NREQ      = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter logic [31:0] ADDR_SIZE = 32'h10000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [32*NREQ-1:0]   req_addr_i,
  input  logic [64*NREQ-1:0]   req_wdata_i,
  input  logic [8*NREQ-1:0]    req_wstrb_i,
  output logic [NREQ-1:0]      resp_valid_o,
  output logic [63:0]          resp_rdata_o,
  output logic [1:0]           resp_err_o,
  output logic [31:0]          m_axi_araddr_o,
  output logic [2:0]           m_axi_arprot_o,
  output logic                 m_axi_arvalid_o,
  input  logic                 m_axi_arready_i,
  input  logic [63:0]          m_axi_rdata_i,
  input  logic [1:0]           m_axi_rresp_i,
  input  logic                 m_axi_rvalid_i,
  output logic                 m_axi_rready_o,
  output logic [31:0]          m_axi_awaddr_o,
  output logic [2:0]           m_axi_awprot_o,
  output logic                 m_axi_awvalid_o,
  input  logic                 m_axi_awready_i,
  output logic [63:0]          m_axi_wdata_o,
  output logic [7:0]           m_axi_wstrb_o,
  output logic                 m_axi_wvalid_o,
  input  logic                 m_axi_wready_i,
  input  logic [1:0]           m_axi_bresp_i,
  input  logic                 m_axi_bvalid_i,
  output logic                 m_axi_bready_o
);

  // state     | meaning
  // IDLE      | search for next requester, accept one command
  // RD_ADDR   | AR channel valid
  // RD_DATA   | waiting for R beat
  // WR        | AW and W issued independently
  // WR_RESP   | waiting for B beat
  // DONE      | one-cycle completion strobe to the granted requester
  typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SPAWN_QUEUE_ARBITER_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  grant_q, grant_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [63:0]    wdata_q, wdata_d;
  logic [7:0]     wstrb_q, wstrb_d;
  logic [63:0]    rdata_q, rdata_d;
  logic [1:0]     err_q, err_d;
  logic           aw_done_q, aw_done_d;
  logic           w_done_q, w_done_d;

  logic           found;
  logic [PW-1:0]  gnt, idx;
  logic [31:0]    sel_addr;
  logic [63:0]    sel_wdata;
  logic [7:0]     sel_wstrb;
  logic           sel_we;
  logic           addr_bad;
  logic           aw_now, w_now;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign sel_addr  = req_addr_i[32*int'(gnt) +: 32];
  assign sel_wdata = req_wdata_i[64*int'(gnt) +: 64];
  assign sel_wstrb = req_wstrb_i[8*int'(gnt) +: 8];
  assign sel_we    = req_we_i[gnt];
  assign addr_bad  = ADDR_CHECK && ((sel_addr < ADDR_BASE) || ({1'b0, sel_addr} >= ADDR_END) ||
                                    (sel_addr[2:0] != 3'b000));

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    aw_done_d       = aw_done_q;
    w_done_d        = w_done_q;
    aw_now          = 1'b0;
    w_now           = 1'b0;
    req_ready_o     = '0;
    resp_valid_o    = '0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = 1'b0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    m_axi_bready_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready_o[gnt] = 1'b1;
          grant_d  = gnt;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          wstrb_d  = sel_wstrb;
          rdata_d  = '0;
          err_d    = 2'b00;
          rr_ptr_d = PW'((int'(gnt) + 1) % NREQ);
          if (addr_bad) begin
            err_d   = 2'b10;
            state_d = S_DONE;
          end else begin
            state_d = sel_we ? S_WR : S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        m_axi_arvalid_o = 1'b1;
        if (m_axi_arready_i) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        m_axi_rready_o = 1'b1;
        if (m_axi_rvalid_i) begin
          rdata_d = m_axi_rdata_i;
          err_d   = m_axi_rresp_i;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        m_axi_awvalid_o = !aw_done_q;
        m_axi_wvalid_o  = !w_done_q;
        // A channel whose valid is up completes the moment its ready is seen.
        aw_now = aw_done_q | m_axi_awready_i;
        w_now  = w_done_q | m_axi_wready_i;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      S_WR_RESP: begin
        m_axi_bready_o = 1'b1;
        if (m_axi_bvalid_i) begin
          err_d   = m_axi_bresp_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        resp_valid_o[grant_q] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign resp_rdata_o   = rdata_q;
  assign resp_err_o     = err_q;
  assign m_axi_araddr_o = addr_q;
  assign m_axi_awaddr_o = addr_q;
  assign m_axi_wdata_o  = wdata_q;
  assign m_axi_wstrb_o  = wstrb_q;
  assign m_axi_arprot_o = 3'b000;
  assign m_axi_awprot_o = 3'b000;

endmodule

// File: tb/tb_spawn_queue_arbiter.sv
// Directed bench for spawn_queue_arbiter (NREQ=3) with a simple AXI4-Lite slave model.
module tb_spawn_queue_arbiter;
  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready, req_we, resp_valid;
  logic [32*NREQ-1:0] req_addr;
  logic [64*NREQ-1:0] req_wdata;
  logic [8*NREQ-1:0]  req_wstrb;
  logic [63:0]        resp_rdata;
  logic [1:0]         resp_err;
  logic [31:0]        araddr, awaddr;
  logic [2:0]         arprot, awprot;
  logic               arvalid, arready, rvalid, rready, awvalid, awready;
  logic               wvalid, wready, bvalid, bready;
  logic [63:0]        rdata, wdata;
  logic [7:0]         wstrb;
  logic [1:0]         rresp, bresp;

  spawn_queue_arbiter #(.NREQ(NREQ)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axi_araddr_o(araddr), .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid),
    .m_axi_arready_i(arready), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready),
    .m_axi_awaddr_o(awaddr), .m_axi_awprot_o(awprot), .m_axi_awvalid_o(awvalid),
    .m_axi_awready_i(awready), .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb),
    .m_axi_wvalid_o(wvalid), .m_axi_wready_i(wready),
    .m_axi_bresp_i(bresp), .m_axi_bvalid_i(bvalid), .m_axi_bready_o(bready)
  );

  // Slave model: R follows an AR handshake, B follows completion of both AW and W.
  logic        r_hold;
  logic [63:0] slv_rdata;
  logic [1:0]  slv_resp;
  logic        r_pend = 1'b0, b_pend = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, arv_cycles = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0;
  logic [63:0] last_wdata = '0;
  logic [7:0]  last_wstrb = '0;
  logic        multi_rdy = 1'b0, multi_resp = 1'b0;
  logic        aw_fire, w_fire;

  assign rvalid  = r_pend & !r_hold;
  assign rdata   = slv_rdata;
  assign rresp   = slv_resp;
  assign bvalid  = b_pend;
  assign bresp   = slv_resp;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  always @(posedge clk) begin
    if (arvalid) arv_cycles <= arv_cycles + 1;
    if (arvalid && arready) begin ar_cnt <= ar_cnt + 1; last_araddr <= araddr; end
    if (aw_fire) begin aw_cnt <= aw_cnt + 1; last_awaddr <= awaddr; end
    if (w_fire) begin w_cnt <= w_cnt + 1; last_wdata <= wdata; last_wstrb <= wstrb; end
    if (rst) begin
      r_pend <= 1'b0; b_pend <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
    end else begin
      if (arvalid && arready) r_pend <= 1'b1;
      else if (rvalid && rready) r_pend <= 1'b0;
      if (bvalid && bready) b_pend <= 1'b0;
      if ((aw_seen || aw_fire) && (w_seen || w_fire)) begin
        b_pend <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen | aw_fire; w_seen <= w_seen | w_fire;
      end
    end
  end

  always @(negedge clk) begin
    if ($countones(req_ready) > 1) multi_rdy <= 1'b1;
    if ($countones(resp_valid) > 1) multi_resp <= 1'b1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  int          lat;
  logic [63:0] got_rdata;
  logic [1:0]  got_err;
  logic        got_onehot;

  task automatic wait_resp(input int idx);
    logic [NREQ-1:0] one;
    bit done;
    one = '0; one[idx] = 1'b1;
    lat = 1; done = resp_valid[idx];
    while (!done && lat < 40) begin
      @(posedge clk); #1; lat++; done = resp_valid[idx];
    end
    got_rdata = resp_rdata; got_err = resp_err; got_onehot = (resp_valid == one);
    if (!done) chk("resp_timeout", 64'(0), 64'(1));
  endtask

  task automatic issue(input int idx, input bit we, input logic [31:0] a,
                       input logic [63:0] wd, input logic [7:0] ws);
    bit acc;
    @(negedge clk);
    req_valid[idx] = 1'b1; req_we[idx] = we;
    req_addr[32*idx +: 32] = a; req_wdata[64*idx +: 64] = wd; req_wstrb[8*idx +: 8] = ws;
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      #1;
      if (req_ready[idx]) acc = 1'b1;
      @(posedge clk);
    end
    #1; req_valid[idx] = 1'b0;
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    wait_resp(idx);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] slv_rdata;
    logic [1:0]  slv_resp;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[6];
  int   grants[6];
  int   ar0, aw0, w0, arv0, n, quiet;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1; r_hold = 1'b0;
    slv_rdata = '0; slv_resp = 2'b00;

    vecs[0] = '{0, 1'b0, 32'h10,   64'h0, 8'h00, 64'h8000_0000_0000_0301, 2'b00, 64'h8000_0000_0000_0301, 2'b00};
    vecs[1] = '{1, 1'b1, 32'h18,   64'h5, 8'hFF, 64'h0, 2'b00, 64'h0, 2'b00};
    vecs[2] = '{2, 1'b0, 32'h20,   64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 2'b10, 64'hDEAD_BEEF_0123_4567, 2'b10};
    vecs[3] = '{0, 1'b1, 32'h100,  64'h1122_3344_5566_7788, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 64'h0, 2'b10};
    vecs[4] = '{1, 1'b0, 32'hFFF8, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[5] = '{2, 1'b1, 32'h8,    64'hCAFE_0000_0000_F00D, 8'h80, 64'h0, 2'b11, 64'h0, 2'b11};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_axi_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'(0));

    // Table: one isolated transaction per vector, immediate slave.
    for (int v = 0; v < 6; v++) begin
      slv_rdata = vecs[v].slv_rdata; slv_resp = vecs[v].slv_resp;
      issue(vecs[v].idx, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'(3));
      chk($sformatf("v%0d_rdata", v), got_rdata, vecs[v].exp_rdata);
      chk($sformatf("v%0d_err", v), 64'(got_err), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_onehot", v), 64'(got_onehot), 64'(1));
      if (vecs[v].we) begin
        chk($sformatf("v%0d_awaddr", v), 64'(last_awaddr), 64'(vecs[v].addr));
        chk($sformatf("v%0d_wdata", v), last_wdata, vecs[v].wdata);
        chk($sformatf("v%0d_wstrb", v), 64'(last_wstrb), 64'(vecs[v].wstrb));
      end else begin
        chk($sformatf("v%0d_araddr", v), 64'(last_araddr), 64'(vecs[v].addr));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_resp_drop", v), 64'(resp_valid), 64'(0));
    end

    // W accepted before AW: W in cycle 1, AW not until cycle 4.
    slv_resp = 2'b00; awready = 1'b0; wready = 1'b1;
    aw0 = aw_cnt; w0 = w_cnt;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[63:32] = 32'h18;
    req_wdata[127:64] = 64'h5; req_wstrb[15:8] = 8'hFF;
    #1; chk("wb_accept", 64'(req_ready), 64'(3'b010));
    @(posedge clk); #1; req_valid[1] = 1'b0;
    chk("wb_c1_valids", 64'({awvalid, wvalid, bready}), 64'(3'b110));
    @(posedge clk); #1; wready = 1'b0;
    chk("wb_c2_valids", 64'({awvalid, wvalid, bready}), 64'(3'b100));
    @(posedge clk); #1;
    chk("wb_c3_valids", 64'({awvalid, wvalid, bready}), 64'(3'b100));
    chk("wb_c3_awaddr", 64'(awaddr), 64'(32'h18));
    @(posedge clk); #1; awready = 1'b1;
    chk("wb_c4_valids", 64'({awvalid, wvalid, bready}), 64'(3'b100));
    @(posedge clk); #1; wready = 1'b1;
    chk("wb_c5_valids", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    chk("wb_c5_resp", 64'(resp_valid), 64'(0));
    @(posedge clk); #1;
    chk("wb_c6_resp", 64'(resp_valid), 64'(3'b010));
    chk("wb_c6_rdata", resp_rdata, 64'h0);
    chk("wb_c6_err", 64'(resp_err), 64'(0));
    @(posedge clk); #1;
    chk("wb_c7_resp", 64'(resp_valid), 64'(0));
    chk("wb_aw_beats", 64'(aw_cnt - aw0), 64'(1));
    chk("wb_w_beats", 64'(w_cnt - w0), 64'(1));
    chk("wb_wdata", last_wdata, 64'h5);

    // Round robin with all three requesters continuously valid.
    do_reset();
    for (int i = 0; i < 6; i++) grants[i] = -1;
    for (int i = 0; i < NREQ; i++) begin
      req_we[i] = 1'b0; req_addr[32*i +: 32] = 32'h200 + 32'(8*i);
    end
    slv_rdata = 64'h77; req_valid = '1;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants[n] = i;
        n++;
      end
      if (n < 6) @(negedge clk);
    end
    @(posedge clk); #1; req_valid = '0;
    repeat (6) @(posedge clk);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(i % NREQ));
    chk("rr_ready_multihot", 64'(multi_rdy), 64'(0));
    chk("resp_multihot", 64'(multi_resp), 64'(0));

    // Reset while waiting for R; then rr_ptr must be back at 0.
    r_hold = 1'b1;
    issue_nowait_read: begin
      @(negedge clk);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[63:32] = 32'h40;
      @(posedge clk); #1; req_valid[1] = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_rready", 64'(rready), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0; r_hold = 1'b0;
      chk("rstmid_axi", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'(0));
      chk("rstmid_ready", 64'(req_ready), 64'(0));
      chk("rstmid_resp", 64'(resp_valid), 64'(0));
    end
    quiet = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid != '0) quiet++;
    end
    chk("rstmid_no_resp", 64'(quiet), 64'(0));
    slv_rdata = 64'hABCD_0000_1234_5678; slv_resp = 2'b00;
    @(negedge clk);
    req_we[1] = 1'b0; req_addr[63:32] = 32'h48;
    req_we[2] = 1'b0; req_addr[95:64] = 32'h50;
    req_valid = 3'b110;
    #1; chk("rstmid_rrptr_grant", 64'(req_ready), 64'(3'b010));
    @(posedge clk); #1; req_valid = '0;
    wait_resp(1);
    chk("rstmid_fresh_lat", 64'(lat), 64'(3));
    chk("rstmid_fresh_rdata", got_rdata, 64'hABCD_0000_1234_5678);
    chk("rstmid_fresh_araddr", 64'(last_araddr), 64'(32'h48));
    @(posedge clk); #1;

    // Out-of-window and misaligned reads.
    slv_rdata = 64'h99; slv_resp = 2'b00;
    ar0 = ar_cnt; arv0 = arv_cycles;
    issue(0, 1'b0, 32'h10000, 64'h0, 8'h00);
`ifdef SPAWN_QUEUE_ARBITER_ADDR_CHECK_EN
    chk("chk_oob_err", 64'(got_err), 64'(2'b10));
    chk("chk_oob_rdata", got_rdata, 64'h0);
    chk("chk_oob_lat", 64'(lat), 64'(1));
`else
    chk("chk_oob_err", 64'(got_err), 64'(0));
    chk("chk_oob_rdata", got_rdata, 64'h99);
    chk("chk_oob_araddr", 64'(last_araddr), 64'(32'h10000));
`endif
    issue(1, 1'b0, 32'h4, 64'h0, 8'h00);
`ifdef SPAWN_QUEUE_ARBITER_ADDR_CHECK_EN
    chk("chk_mis_err", 64'(got_err), 64'(2'b10));
    chk("chk_mis_rdata", got_rdata, 64'h0);
    chk("chk_no_ar_beats", 64'(ar_cnt - ar0), 64'(0));
    chk("chk_no_arvalid", 64'(arv_cycles - arv0), 64'(0));
`else
    chk("chk_mis_err", 64'(got_err), 64'(0));
    chk("chk_mis_araddr", 64'(last_araddr), 64'(32'h4));
    chk("chk_ar_beats", 64'(ar_cnt - ar0), 64'(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
